// File: rtl/alu_share_arb.sv
// Shares one single-cycle ALU between two round-robin requesters; results return on a shared, ID-tagged response bus.
// Latency: an op accepted at edge N shows rsp_valid in the cycle after edge N+1 (2 cycles), 1 op/cycle sustained.
// Backpressure: rsp_ready low holds W stable; once E is also full both req readys drop (at most 2 ops in flight).
module alu_share_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_acl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_acl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // E stage: operands of the op currently feeding the ALU
    logic        e_valid;
    logic        e_id;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [3:0]  e_acl;

    // W stage: registered result, drives the response bus directly
    logic        w_valid;
    logic        w_id;
    logic [31:0] w_result;
    logic        w_zero;
    logic        w_err;

    logic        last_grant;
    logic        grant;
    logic        w_adv;
    logic        e_adv;
    logic        accept;
    logic [31:0] alu_res;
    logic        alu_illegal;
    logic        big_shift;

    assign w_adv = !w_valid || rsp_ready;
    assign e_adv = !e_valid || w_adv;

    // Round-robin pick: a lone valid requester wins, otherwise whoever was not granted last
    always_comb begin
        grant = !last_grant;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = e_adv && !grant && !rst;
    assign req1_ready = e_adv && grant && !rst;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign alu_illegal = e_acl[3];
    assign big_shift   = |e_b[31:5];

    // Single-cycle ALU evaluated from the E stage; shifts of 32 or more flush to zero
    always_comb begin
        alu_res = 32'd0;
        case (e_acl)
            4'd0: alu_res = e_a + e_b;
            4'd1: alu_res = e_a - e_b;
            4'd2: alu_res = big_shift ? 32'd0 : (e_a << e_b[4:0]);
            4'd3: alu_res = {31'd0, (e_a < e_b)};
            4'd4: alu_res = e_a ^ e_b;
            4'd5: alu_res = big_shift ? 32'd0 : (e_a >> e_b[4:0]);
            4'd6: alu_res = e_a | e_b;
            4'd7: alu_res = e_a & e_b;
            default: alu_res = 32'd0;
        endcase
    end

    // E stage load: refills whenever it can advance, capturing the granted requester's operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid    <= 1'b0;
            e_id       <= 1'b0;
            e_a        <= 32'd0;
            e_b        <= 32'd0;
            e_acl      <= 4'd0;
            last_grant <= 1'b1;
        end else if (e_adv) begin
            e_valid <= accept;
            if (accept) begin
                e_id       <= grant;
                e_a        <= grant ? req1_a   : req0_a;
                e_b        <= grant ? req1_b   : req0_b;
                e_acl      <= grant ? req1_acl : req0_acl;
                last_grant <= grant;
            end
        end
    end

    // W stage load: holds under backpressure, illegal opcodes bypass the ALU output entirely
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_valid  <= 1'b0;
            w_id     <= 1'b0;
            w_result <= 32'd0;
            w_zero   <= 1'b0;
            w_err    <= 1'b0;
        end else if (w_adv) begin
            w_valid <= e_valid;
            if (e_valid) begin
                w_id     <= e_id;
                w_result <= alu_illegal ? 32'd0 : alu_res;
                w_zero   <= alu_illegal ? 1'b1 : (alu_res == 32'd0);
                w_err    <= alu_illegal;
            end
        end
    end

    // Per-requester completion counters, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (w_valid && rsp_ready) begin
            if (!w_id && cnt0 != CNT_MAX) begin
                cnt0 <= cnt0 + CNT_ONE;
            end
            if (w_id && cnt1 != CNT_MAX) begin
                cnt1 <= cnt1 + CNT_ONE;
            end
        end
    end

    assign rsp_valid  = w_valid;
    assign rsp_id     = w_id;
    assign rsp_result = w_result;
    assign rsp_zero   = w_zero;
    assign rsp_err    = w_err;

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_acl, req1_acl;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_result;
    logic [1:0]  cnt0, cnt1;

    alu_share_arb #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_acl(req0_acl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_acl(req1_acl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  acl;
        logic [31:0] res;
        logic        z;
        logic        e;
    } op_t;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        z;
        logic        e;
    } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];
    int   log_id[$];
    int   log_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   acc0 = 0;
    int   acc1 = 0;
    int   cyc = 0;

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] acl,
                               input logic [31:0] res, input logic z, input logic e);
        op_t o;
        o.a = a; o.b = b; o.acl = acl; o.res = res; o.z = z; o.e = e;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size() + sb.size());
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Driver: presents queue heads, records accepts and pushes expected responses
    initial begin
        logic s0, s1;
        exp_t x;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_acl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_acl = '0;
        forever begin
            @(negedge clk);
            s0 = req0_valid && req0_ready;
            s1 = req1_valid && req1_ready;
            @(posedge clk);
            if (s0 && q0.size() != 0) begin
                x.id = 1'b0; x.res = q0[0].res; x.z = q0[0].z; x.e = q0[0].e;
                sb.push_back(x);
                void'(q0.pop_front());
                acc0++;
            end
            if (s1 && q1.size() != 0) begin
                x.id = 1'b1; x.res = q1[0].res; x.z = q1[0].z; x.e = q1[0].e;
                sb.push_back(x);
                void'(q1.pop_front());
                acc1++;
            end
            #1;
            if (q0.size() != 0) begin
                req0_valid = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b; req0_acl = q0[0].acl;
            end else begin
                req0_valid = 1'b0;
            end
            if (q1.size() != 0) begin
                req1_valid = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b; req1_acl = q1[0].acl;
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    // Monitor: every response handshake is compared against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d res=%h expected no response", rsp_id, rsp_result);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== e) begin
                        errors++;
                        $display("FAIL rsp: got id=%0d res=%h z=%0d e=%0d expected id=%0d res=%h z=%0d e=%0d",
                                 rsp_id, rsp_result, rsp_zero, rsp_err, e.id, e.res, e.z, e.e);
                    end
                    log_id.push_back(int'(rsp_id));
                    log_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        int a0;
        int k;
        logic [34:0] snap;

        rst = 1'b1;
        rsp_ready = 1'b1;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_zero_err", {30'd0, rsp_zero, rsp_err}, 32'd0);
        check("rst_cnt", {28'd0, cnt0, cnt1}, 32'd0);
        check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("ready_after_rst", 32'(req0_ready), 32'd1);

        // Single op and latency
        @(posedge clk); #2;
        q0.push_back(mk(32'd5, 32'd7, 4'd0, 32'd12, 1'b0, 1'b0));
        k = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) begin
                k = i;
                break;
            end
        end
        if (k < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end else begin
            @(negedge clk);
            check("lat_e_cycle", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            check("lat_w_cycle", 32'(rsp_valid), 32'd1);
        end
        wait_drain();
        check("cnt0_single", 32'(cnt0), 32'd1);

        // Zero flag and unsigned compare from requester 1
        q1.push_back(mk(32'd9, 32'd9, 4'd1, 32'd0, 1'b1, 1'b0));
        q1.push_back(mk(32'd1, 32'hFFFF_FFFF, 4'd3, 32'd1, 1'b0, 1'b0));
        wait_drain();
        check("cnt1_two", 32'(cnt1), 32'd2);

        // Conflict round-robin
        log_id.delete();
        log_cyc.delete();
        q0.push_back(mk(32'd1, 32'd2, 4'd0, 32'd3, 1'b0, 1'b0));
        q0.push_back(mk(32'hF0, 32'hFF, 4'd4, 32'h0F, 1'b0, 1'b0));
        q0.push_back(mk(32'h100, 32'h1, 4'd6, 32'h101, 1'b0, 1'b0));
        q1.push_back(mk(32'hFF, 32'h0F, 4'd7, 32'h0F, 1'b0, 1'b0));
        q1.push_back(mk(32'd10, 32'd3, 4'd1, 32'd7, 1'b0, 1'b0));
        q1.push_back(mk(32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1, 1'b0));
        wait_drain();
        check("rr_count", 32'(log_id.size()), 32'd6);
        if (log_id.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("rr_id%0d", i), 32'(log_id[i]), 32'(i % 2));
            end
            for (int i = 1; i < 6; i++) begin
                check($sformatf("rr_gap%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
            end
        end

        // Backpressure
        rsp_ready = 1'b0;
        a0 = acc0;
        q0.push_back(mk(32'd100, 32'd23, 4'd0, 32'd123, 1'b0, 1'b0));
        q0.push_back(mk(32'd5, 32'd6, 4'd1, 32'hFFFF_FFFF, 1'b0, 1'b0));
        q0.push_back(mk(32'd3, 32'd4, 4'd2, 32'h30, 1'b0, 1'b0));
        q0.push_back(mk(32'hF0F0, 32'h0FF0, 4'd7, 32'h00F0, 1'b0, 1'b0));
        repeat (5) @(posedge clk);
        #2;
        check("bp_accepts", 32'(acc0 - a0), 32'd2);
        check("bp_ready_low", 32'(req0_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_head_result", rsp_result, 32'd123);
        snap = {rsp_valid, rsp_id, rsp_result, rsp_zero};
        repeat (2) @(posedge clk);
        #2;
        check("bp_hold_hi", {29'd0, snap[34:32]}, {29'd0, rsp_valid, rsp_id, rsp_result[31]});
        check("bp_hold_lo", snap[31:0], {rsp_result[30:0], rsp_zero});
        check("bp_hold_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        wait_drain();
        check("bp_total_accepts", 32'(acc0 - a0), 32'd4);

        // Illegal opcode and shift edges
        q0.push_back(mk(32'd3, 32'd4, 4'd9, 32'd0, 1'b1, 1'b1));
        q0.push_back(mk(32'd1, 32'd32, 4'd2, 32'd0, 1'b1, 1'b0));
        q0.push_back(mk(32'h8000_0000, 32'd31, 4'd5, 32'd1, 1'b0, 1'b0));
        q0.push_back(mk(32'd1, 32'd4, 4'd2, 32'd16, 1'b0, 1'b0));
        q0.push_back(mk(32'hA, 32'hC, 4'd4, 32'h6, 1'b0, 1'b0));
        wait_drain();

        // Reset with two ops in flight
        rsp_ready = 1'b0;
        a0 = acc0;
        q0.push_back(mk(32'd7, 32'd8, 4'd0, 32'd15, 1'b0, 1'b0));
        q0.push_back(mk(32'd7, 32'd7, 4'd4, 32'd0, 1'b1, 1'b0));
        repeat (5) @(posedge clk);
        #2;
        check("mid_accepts", 32'(acc0 - a0), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        check("mid_rst_cnt", {28'd0, cnt0, cnt1}, 32'd0);
        sb.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        rsp_ready = 1'b1;
        #1 check("mid_ready_after", 32'(req0_ready), 32'd1);
        repeat (4) @(posedge clk);
        #2;
        check("mid_no_rsp", 32'(rsp_valid), 32'd0);

        // Counter saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            q1.push_back(mk(32'(i), 32'(i), 4'd0, 32'(2 * i), (i == 0), 1'b0));
        end
        wait_drain();
        check("sat_cnt1", 32'(cnt1), 32'd3);
        check("sat_cnt0", 32'(cnt0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Shares the single-cycle core ALU (4-bit `acl` opcode, 32-bit operands, zero flag) between two requesters, e.g. the integer execute path and the address/branch-compare path. Grants are round-robin with a valid/ready handshake per requester. The block registers operands and results in a two-stage pipeline: an E stage holding operands, and a W stage holding the result. Results return on one shared response bus tagged with the requester ID and held under backpressure.

## Interface
- `CNT_W`, default 16: width of the per-requester saturating completion counters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: the requester presents an operation.
- `req0_ready` / `req1_ready` out 1: the operation is accepted at the edge where valid & ready.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 32: operands.
- `req0_acl` / `req1_acl` in 4: ALU opcode.
- `rsp_valid` out 1: a result is presented.
- `rsp_ready` in 1: the consumer takes the result at the edge where rsp_valid & rsp_ready.
- `rsp_id` out 1: requester that issued the op.
- `rsp_result` out 32: ALU result.
- `rsp_zero` out 1: result == 0.
- `rsp_err` out 1: opcode was illegal (8–15).
- `cnt0` / `cnt1` out CNT_W: completed responses per requester, saturating.

## Operation
- Opcodes:
  - 0 add, 1 sub, 2 sll, 3 unsigned set-less-than, 4 xor, 5 srl, 6 or, 7 and.
  - All arithmetic is modulo 2^32.
  - Shifts use the full 32-bit b; a shift amount ≥ 32 yields 0.
- Illegal acl (8–15):
  - The op is accepted normally.
  - W captures result 0, zero = 1, err = 1.
  - The ALU output is never used for these ops.
- E stage: `e_valid`, `e_id`, `e_a`, `e_b`, `e_acl`. The ALU is driven combinationally from E.
- W stage: `w_valid`, `w_id`, `w_result`, `w_zero`, `w_err`. `rsp_*` are driven directly from W.
- Advance conditions:
  - `w_adv` = !w_valid | rsp_ready.
  - `e_adv` = !e_valid | w_adv.
  - E moves into W when e_valid & w_adv.
- Arbitration:
  - Only when e_adv is true is a grant possible.
  - With one requester valid, grant it.
  - With both valid, grant the requester not granted last.
  - `last_grant` updates only on an actual acceptance.
- `reqN_ready` = e_adv & grant==N & !rst. It is combinational and may depend on both reqN_valid inputs. It is never asserted for a requester that loses arbitration in that cycle.
- Counters: cntN increments on a response handshake with rsp_id==N. It saturates at 2^CNT_W−1 and does not wrap.
- No reordering: responses leave in acceptance order.

## Timing
- Reset values:
  - e_valid = 0, w_valid = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0, rsp_err = 0.
  - cnt0 = cnt1 = 0.
  - last_grant = 1, so requester 0 wins the first conflict.
  - req*_ready = 0 while rst is high.
- Reset mid-operation: in-flight E and W contents are discarded with no response. Ready is available in the first cycle after deassertion.
- Latency:
  - Op accepted at edge N is in E during cycle N+1.
  - Its result is registered at edge N+1, so rsp_valid is high in cycle N+2 (2 cycles).
- Throughput: 1 op/cycle with rsp_ready held high. Alternation is strict when both requesters are continuously valid.
- Backpressure:
  - rsp_valid=1 & rsp_ready=0: W holds and all rsp_* outputs are stable.
  - If E is also full: both req readys are 0.
  - Maximum of 2 ops in flight.
- Simultaneous events:
  - A response handshake and an E→W move in the same cycle leave W refilled with no bubble.
  - A new accept into E in the same cycle is permitted.
- Requester inputs are sampled only at the accepting edge. Requester-side signal changes while valid & !ready are legal and not checked.

## Test plan
- Single op: req0 add a=5, b=7, rsp_ready=1, accepted at edge N.
  - Cycle N+2: rsp_valid=1, id=0, result=12, zero=0, err=0.
  - cnt0=1 after the handshake.
- Zero and compare:
  - req1 sub a=9, b=9 → result 0, zero=1.
  - Then op 3 with a=1, b=0xFFFF_FFFF → result 1 (unsigned compare).
- Conflict round-robin:
  - Both valid continuously for 6 ops with rsp_ready=1.
  - rsp_id sequence is 0,1,0,1,0,1 at 1 response/cycle.
- Backpressure: stream from req0 with rsp_ready=0 for 4 cycles.
  - Exactly 2 ops are accepted and req0_ready drops.
  - rsp_* are held stable.
  - After release, results arrive in order with no loss or duplication.
- Illegal opcode and shift edge:
  - acl=9 → result 0, zero=1, err=1.
  - sll with a=1, b=32 → result 0.
  - srl with a=0x8000_0000, b=31 → result 1.
- Reset mid-flight and counters:
  - Assert rst with 2 ops in flight → no responses, cnt=0, rsp_valid=0 immediately (asynchronous).
  - With CNT_W=2, 5 responses → cnt holds at 3.
